// File: rtl/playbus_sequencer.sv
// PlayBus level 2 stored-program sequencer.
// Fetches ROM words and replays them as PlayBus strobe cycles.
module playbus_sequencer #(
  parameter int AW       = 5,
  parameter int PROG_LEN = 32,
  parameter bit LOOP     = 1'b0
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic [AW+2:0] instr,
  output logic [AW-1:0] addr,
  output logic          ROMO,
  output logic          RAMO,
  output logic          RAMW,
  output logic          SWBEN,
  output logic          LEDLTCH,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    XFER,
    PAUSE,
    HALT
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(PROG_LEN - 1);

  state_t        state;
  state_t        fin_state;
  logic [AW+2:0] ir;
  logic [AW-1:0] fin_pc;
  logic [2:0]    func;
  logic [AW-1:0] opnd;
  logic          step_q;
  logic          long_op;

  assign func    = ir[AW+2:AW];
  assign opnd    = ir[AW-1:0];
  assign long_op = (func >= 3'd3);

  // Where an instruction goes once it completes.
  always_comb begin
    fin_pc    = pc;
    fin_state = step_mode ? PAUSE : FETCH;
    if (pc == LAST && !LOOP) begin
      fin_state = HALT;
    end else if (pc == LAST) begin
      fin_pc = '0;
    end else begin
      fin_pc = pc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state  <= IDLE;
      pc     <= '0;
      ir     <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= step;
      unique case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          ir    <= instr;
          state <= EXEC;
        end
        EXEC: begin
          if (long_op) begin
            state <= XFER;
          end else begin
            state <= fin_state;
            pc    <= fin_pc;
          end
        end
        XFER: begin
          state <= fin_state;
          pc    <= fin_pc;
        end
        PAUSE: begin
          if (step && !step_q) state <= FETCH;
        end
        HALT: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode: state, pc and ir only.
  always_comb begin
    addr    = '0;
    ROMO    = 1'b0;
    RAMO    = 1'b0;
    RAMW    = 1'b0;
    SWBEN   = 1'b0;
    LEDLTCH = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    unique case (1'b1)
      (state == FETCH): begin
        addr = pc;
        ROMO = 1'b1;
        busy = 1'b1;
      end
      (state == EXEC),
      (state == XFER): begin
        addr = opnd;
        busy = 1'b1;
        case (func)
          3'd0, 3'd4:       ROMO  = 1'b1;
          3'd1, 3'd7:       RAMO  = 1'b1;
          3'd2, 3'd3, 3'd5: SWBEN = 1'b1;
          default:          ;
        endcase
        if (state == EXEC) begin
          RAMW    = (func == 3'd3) || (func == 3'd4);
          LEDLTCH = (func >= 3'd5);
        end
      end
      (state == HALT): halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_playbus_sequencer.sv
// Directed self-checking bench for playbus_sequencer.
// Three instances cover the default, halting and looping builds.
module tb_playbus_sequencer;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic start = 1'b0;
  logic step_mode = 1'b0;
  logic step = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic [7:0] rom0 [32];
  logic [7:0] rom1 [32];

  logic [4:0] a0, p0, a1, p1, a2, p2;
  logic romo0, ramo0, ramw0, swb0, led0, busy0, hlt0;
  logic romo1, ramo1, ramw1, swb1, led1, busy1, hlt1;
  logic romo2, ramo2, ramw2, swb2, led2, busy2, hlt2;
  logic [7:0] i0, i1, i2;

  assign i0 = rom0[a0];
  assign i1 = rom1[a1];
  assign i2 = rom1[a2];

  playbus_sequencer u0 (
    .clk(clk), .n_reset(n_reset), .start(start),
    .step_mode(step_mode), .step(step), .instr(i0),
    .addr(a0), .ROMO(romo0), .RAMO(ramo0), .RAMW(ramw0),
    .SWBEN(swb0), .LEDLTCH(led0), .pc(p0),
    .busy(busy0), .halted(hlt0)
  );

  playbus_sequencer #(.PROG_LEN(4), .LOOP(1'b0)) u1 (
    .clk(clk), .n_reset(n_reset), .start(start),
    .step_mode(1'b0), .step(1'b0), .instr(i1),
    .addr(a1), .ROMO(romo1), .RAMO(ramo1), .RAMW(ramw1),
    .SWBEN(swb1), .LEDLTCH(led1), .pc(p1),
    .busy(busy1), .halted(hlt1)
  );

  playbus_sequencer #(.PROG_LEN(4), .LOOP(1'b1)) u2 (
    .clk(clk), .n_reset(n_reset), .start(start),
    .step_mode(1'b0), .step(1'b0), .instr(i2),
    .addr(a2), .ROMO(romo2), .RAMO(ramo2), .RAMW(ramw2),
    .SWBEN(swb2), .LEDLTCH(led2), .pc(p2),
    .busy(busy2), .halted(hlt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {addr,ROMO,RAMO,RAMW,SWBEN,LEDLTCH,busy,halted} of u0
  function automatic logic [31:0] bus0();
    return {a0, romo0, ramo0, ramw0, swb0, led0, busy0, hlt0};
  endfunction

  function automatic logic [31:0] vec(input logic [4:0] ad,
                                      input logic [6:0] f);
    return {ad, f};
  endfunction

  task automatic do_reset();
    n_reset = 1'b0;
    start = 1'b0;
    step = 1'b0;
    tick();
    tick();
    n_reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom0[i] = 8'h00;
      rom1[i] = {3'd2, 5'(i)};
    end

    do_reset();
    chk("rst_bus", bus0(), vec(5'd0, 7'b0000000));
    chk("rst_pc", p0, 5'd0);
    chk("rst_u1", {p1, busy1, hlt1, romo1}, 0);

    // 1: func 3 SWBEN -> RAMW
    rom0[0] = {3'd3, 5'd5};
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_fetch", bus0(), vec(5'd0, 7'b1000010));
    tick();
    chk("t1_exec", bus0(), vec(5'd5, 7'b0011010));
    tick();
    chk("t1_xfer", bus0(), vec(5'd5, 7'b0001010));
    tick();
    chk("t1_fetch2", bus0(), vec(5'd1, 7'b1000010));
    chk("t1_pc", p0, 5'd1);

    // 2: func 1 then func 7
    do_reset();
    rom0[0] = {3'd1, 5'd9};
    rom0[1] = {3'd7, 5'd2};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t2_exec1", bus0(), vec(5'd9, 7'b0100010));
    tick();
    chk("t2_fetch", bus0(), vec(5'd1, 7'b1000010));
    tick();
    chk("t2_exec2", bus0(), vec(5'd2, 7'b0100110));
    tick();
    chk("t2_xfer2", bus0(), vec(5'd2, 7'b0100010));
    tick();
    chk("t2_fetch3", bus0(), vec(5'd2, 7'b1000010));

    // 3 and 4: four func-2 words, halting and looping builds
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("t4_busy", {busy2, hlt2}, 2'b10);
      if (i % 2 == 0) chk("t4_pc", p2, 5'((i / 2) % 4));
      if (i == 7) chk("t3_exec3", {p1, swb1, busy1}, {5'd3, 2'b11});
      if (i == 8)
        chk("t3_halt", {a1, romo1, ramo1, ramw1, swb1, led1,
                        busy1, hlt1, p1}, {5'd0, 7'b0000001, 5'd3});
      if (i == 10) chk("t3_hold", {hlt1, p1}, {1'b1, 5'd3});
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_restart", {a1, romo1, busy1, hlt1, p1},
        {5'd0, 3'b110, 5'd0});

    // 5: single step
    do_reset();
    for (int i = 0; i < 4; i++) rom0[i] = {3'd0, 5'(i + 8)};
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t5_pause", {bus0(), p0}, {vec(5'd0, 7'b0), 5'd1});
    step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_hold", {busy0, p0}, {1'b0, 5'd2});
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("t5_fetch", bus0(), vec(5'd2, 7'b1000010));
    tick();
    chk("t5_exec", bus0(), vec(5'd10, 7'b1000010));
    tick();
    chk("t5_pause2", {busy0, p0}, {1'b0, 5'd3});
    step_mode = 1'b0;

    // 6: reset while RAMW is high
    do_reset();
    rom0[0] = {3'd4, 5'd7};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t6_exec", bus0(), vec(5'd7, 7'b1010010));
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    chk("t6_rst", {bus0(), p0}, {vec(5'd0, 7'b0), 5'd0});
    for (int i = 0; i < 5; i++) tick();
    chk("t6_idle", {bus0(), p0}, {vec(5'd0, 7'b0), 5'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
